port_arbiter: RTL and testbench

PORT_ARBITER -- requirements
Module: port_arbiter

---
 rtl/port_arbiter.sv | 124 ++++++++++++
 tb/tb_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/port_arbiter.sv
// rtl/port_arbiter.sv - two-requester round-robin arbiter for a shared ports block
module port_arbiter #(
  parameter int WORD_WIDTH = 16,
  parameter int PRIO_RESET = 0
) (
  input  logic                  clk,
  input  logic                  do_reset_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [WORD_WIDTH-1:0] addr0,
  input  logic [WORD_WIDTH-1:0] addr1,
  input  logic [WORD_WIDTH-1:0] wdata0,
  input  logic [WORD_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [WORD_WIDTH-1:0] rdata,
  output logic [WORD_WIDTH-1:0] portaddr,
  output logic [WORD_WIDTH-1:0] portval,
  output logic                  portget,
  output logic                  portset,
  input  logic [WORD_WIDTH-1:0] portout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // Pointer value that makes the PRIO_RESET requester win the first tie.
  localparam logic LAST_RST = (PRIO_RESET != 0) ? 1'b0 : 1'b1;

  state_t                state_q, state_d;
  logic                  last_q, last_d;    // requester granted most recently
  logic                  owner_q, owner_d;  // requester owning the access in flight
  logic                  we_q, we_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic                  pick;

  // Next-state, arbitration and strobe decode; every output defaults low.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    pick    = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    portget = 1'b0;
    portset = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Tie goes to the requester not served last; otherwise the lone requester.
          pick    = (req0 && req1) ? ~last_q : req1;
          // Gate with reset so a held req cannot show a grant while in reset.
          gnt0    = ~pick & do_reset_n;
          gnt1    = pick & do_reset_n;
          owner_d = pick;
          last_d  = pick;
          we_d    = pick ? we1 : we0;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        portset = we_q;
        portget = ~we_q;
        // The ports block answers within the strobe cycle; rdata is then
        // stable for the whole CAPTURE cycle in which done pulses.
        if (!we_q) begin
          rdata_d = portout;
        end
        state_d = CAPTURE;
      end
      CAPTURE: begin
        done0   = ~owner_q;
        done1   = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-request registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge do_reset_n) begin
    if (!do_reset_n) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign portaddr = addr_q;
  assign portval  = wdata_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_port_arbiter.sv
// tb/tb_port_arbiter.sv - scoreboard bench for port_arbiter
module tb_port_arbiter;

  localparam int W = 16;
  localparam int PRIO = 0;

  logic         clk = 1'b0;
  logic         do_reset_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [W-1:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic         gnt0, gnt1, done0, done1, portget, portset;
  logic [W-1:0] rdata, portaddr, portval, portout;
  logic [W-1:0] port_mask = '0;

  port_arbiter #(.WORD_WIDTH(W), .PRIO_RESET(PRIO)) dut (
    .clk(clk), .do_reset_n(do_reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .portaddr(portaddr), .portval(portval),
    .portget(portget), .portset(portset), .portout(portout)
  );

  // Ports block model: read data is a fixed function of the address.
  always_comb portout = portaddr ^ port_mask;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int           cyc;
    bit           id;
    bit           we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
  } txn_t;

  txn_t gq[$];
  txn_t sq[$];
  txn_t dq[$];

  // Reference model: a server that takes one request every three cycles,
  // picking round-robin among the raised requests.
  int           free_at = 0;
  bit           m_last = (PRIO == 0);
  logic [W-1:0] m_rdata = '0;
  bit           g0 = 0, g1 = 0;

  task automatic model_cycle();
    txn_t t;
    bit   w;
    g0 = 0;
    g1 = 0;
    if (cyc >= free_at && (req0 || req1)) begin
      w = (req0 && req1) ? !m_last : req1;
      m_last = w;
      t.id    = w;
      t.we    = w ? we1 : we0;
      t.addr  = w ? addr1 : addr0;
      t.wdata = w ? wdata1 : wdata0;
      if (!t.we) m_rdata = t.addr ^ port_mask;
      t.rdata = m_rdata;
      t.cyc = cyc;     gq.push_back(t);
      t.cyc = cyc + 1; sq.push_back(t);
      t.cyc = cyc + 2; dq.push_back(t);
      free_at = cyc + 3;
      if (w) g1 = 1; else g0 = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      model_cycle();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_gnt"}, {gnt0, gnt1}, 0);
    check({tag, "_done"}, {done0, done1}, 0);
    check({tag, "_strobe"}, {portget, portset}, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_portaddr"}, portaddr, 0);
    check({tag, "_portval"}, portval, 0);
  endtask

  // Called just after a rising edge; reset is low for part of that cycle only.
  task automatic pulse_reset(input string tag);
    do_reset_n = 1'b0;
    gq.delete(); sq.delete(); dq.delete();
    #1;
    check_zero_outputs(tag);
    #2;
    do_reset_n = 1'b1;
    m_last  = (PRIO == 0);
    m_rdata = '0;
    free_at = cyc + 1;
    g0 = 0;
    g1 = 0;
  endtask

  task automatic one_shot(input bit id, input bit we, input logic [W-1:0] a, input logic [W-1:0] d);
    tick();
    if (id) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    else    begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    model_cycle();
    tick();
    req0 = 0;
    req1 = 0;
    model_cycle();
    idle(3);
  endtask

  // Monitor: every cycle the outputs must match what the queues expect now.
  always @(negedge clk) begin : monitor
    txn_t t;
    bit   eg0, eg1, eget, eset, ed0, ed1;
    if (do_reset_n) begin
      eg0 = 0; eg1 = 0; eget = 0; eset = 0; ed0 = 0; ed1 = 0;
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        t = gq.pop_front();
        eg0 = !t.id;
        eg1 = t.id;
      end
      check("gnt0", gnt0, eg0);
      check("gnt1", gnt1, eg1);
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        t = sq.pop_front();
        eget = !t.we;
        eset = t.we;
        check("portaddr", portaddr, t.addr);
        if (t.we) check("portval", portval, t.wdata);
      end
      check("portget", portget, eget);
      check("portset", portset, eset);
      if (dq.size() > 0 && dq[0].cyc == cyc) begin
        t = dq.pop_front();
        ed0 = !t.id;
        ed1 = t.id;
        check("rdata", rdata, t.rdata);
      end
      check("done0", done0, ed0);
      check("done1", done1, ed1);
    end
  end

  initial begin
    // Reset state, with a request already raised to confirm no grant leaks out.
    req0 = 1;
    #2;
    check_zero_outputs("reset");
    #20;
    req0 = 0;
    do_reset_n = 1'b1;

    // Read by requester 0 alone.
    port_mask = 16'h0010 ^ 16'hBEEF;
    one_shot(0, 0, 16'h0010, 16'h0000);

    // Write by requester 1 alone; rdata keeps the earlier read value.
    one_shot(1, 1, 16'h0003, 16'h1234);

    // Full-width pass-through.
    port_mask = 16'h0000;
    one_shot(0, 0, 16'hFFFF, 16'h0000);
    one_shot(1, 1, 16'hFFFF, 16'hFFFF);

    // Both requesting continuously from reset: alternating grants every 3 cycles.
    tick();
    pulse_reset("rst_rr");
    for (int i = 0; i < 13; i++) begin
      tick();
      req0 = 1; we0 = 1'($urandom_range(1)); addr0 = 16'($urandom); wdata0 = 16'($urandom);
      req1 = 1; we1 = 1'($urandom_range(1)); addr1 = 16'($urandom); wdata1 = 16'($urandom);
      model_cycle();
    end
    tick();
    req0 = 0;
    req1 = 0;
    model_cycle();
    idle(4);

    // Reset pulse during ISSUE aborts the access.
    port_mask = 16'h5A5A;
    tick();
    req0 = 1; we0 = 0; addr0 = 16'h0042;
    model_cycle();
    tick();
    req0 = 0;
    check("issue_get", portget, 1);
    pulse_reset("rst_issue");
    idle(6);

    // Randomized traffic.
    port_mask = 16'($urandom);
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (g0) begin
        if ($urandom_range(1) == 1) req0 = 0;
        else begin req0 = 1; we0 = 1'($urandom_range(1)); addr0 = 16'($urandom); wdata0 = 16'($urandom); end
      end else if (!req0 && $urandom_range(2) == 0) begin
        req0 = 1; we0 = 1'($urandom_range(1)); addr0 = 16'($urandom); wdata0 = 16'($urandom);
      end
      if (g1) begin
        if ($urandom_range(1) == 1) req1 = 0;
        else begin req1 = 1; we1 = 1'($urandom_range(1)); addr1 = 16'($urandom); wdata1 = 16'($urandom); end
      end else if (!req1 && $urandom_range(2) == 0) begin
        req1 = 1; we1 = 1'($urandom_range(1)); addr1 = 16'($urandom); wdata1 = 16'($urandom);
      end
      model_cycle();
    end

    // Drain: no new requests, pending ones are served then dropped.
    for (int i = 0; i < 12; i++) begin
      tick();
      if (g0) req0 = 0;
      if (g1) req1 = 0;
      model_cycle();
    end
    idle(4);
    @(posedge clk);
    #1;
    check("queues_empty", gq.size() + sq.size() + dq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
